// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access unit: drives a req/ack data bus, aligns load/store
// lanes and stalls the upstream pipeline while an access is outstanding.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        RegWrite_in,
    input  logic [1:0]  MemSize_in,
    input  logic        MemSigned_in,
    input  logic [31:0] ALU_in,
    input  logic [31:0] StoreData_in,
    input  logic [4:0]  Rd_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic        mem_err,
    output logic        RegWrite_out,
    output logic        MemRead_out,
    output logic [31:0] Mem_out,
    output logic [31:0] ALU_out,
    output logic [4:0]  Rd_out
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [31:0]        load_buf, load_buf_nx;
    logic               timed_out, timed_out_nx;

    logic               mem_op, bad, reg_ok;
    logic [3:0]         be_w;
    logic [31:0]        wdata_w, load_data;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;

    // Instruction decode, lane steering and load extraction
    always_comb begin
        mem_op   = ex_valid & (MemRead_in | MemWrite_in);
        bad      = (MemRead_in & MemWrite_in) | (MemSize_in == 2'b11)
                 | ((MemSize_in == 2'b01) & ALU_in[0])
                 | ((MemSize_in == 2'b10) & (ALU_in[1:0] != 2'b00));
        reg_ok   = RegWrite_in & ex_valid & (Rd_in != 5'd0) & ~MemWrite_in;
        byte_sel = dmem_rdata[{ALU_in[1:0], 3'b000} +: 8];
        half_sel = dmem_rdata[{ALU_in[1], 4'b0000} +: 16];
        be_w      = 4'b1111;
        wdata_w   = StoreData_in;
        load_data = dmem_rdata;
        case (MemSize_in)
            2'b00: begin
                be_w      = 4'(4'b0001 << ALU_in[1:0]);
                wdata_w   = {4{StoreData_in[7:0]}};
                load_data = {{24{MemSigned_in & byte_sel[7]}}, byte_sel};
            end
            2'b01: begin
                be_w      = ALU_in[1] ? 4'b1100 : 4'b0011;
                wdata_w   = {2{StoreData_in[15:0]}};
                load_data = {{16{MemSigned_in & half_sel[15]}}, half_sel};
            end
            default: ;
        endcase
    end

    // Next-state and outputs; everything is forced quiet while rst is high
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        load_buf_nx  = load_buf;
        timed_out_nx = timed_out;
        dmem_req     = 1'b0;
        dmem_we      = MemWrite_in;
        dmem_addr    = {ALU_in[31:2], 2'b00};
        dmem_be      = MemWrite_in ? be_w : 4'b1111;
        dmem_wdata   = wdata_w;
        stall        = 1'b0;
        mem_err      = 1'b0;
        RegWrite_out = 1'b0;
        MemRead_out  = 1'b0;
        Mem_out      = 32'd0;
        ALU_out      = ALU_in;
        Rd_out       = Rd_in;
        case (state)
            IDLE: begin
                cnt_nx       = '0;
                timed_out_nx = 1'b0;
                load_buf_nx  = 32'd0;
                if (mem_op && bad) begin
                    mem_err = 1'b1;
                end else if (mem_op) begin
                    dmem_req = 1'b1;
                    stall    = 1'b1;
                    state_nx = WAIT;
                end else begin
                    RegWrite_out = reg_ok;
                    MemRead_out  = ex_valid & MemRead_in;
                end
            end
            WAIT: begin
                dmem_req = 1'b1;
                stall    = 1'b1;
                cnt_nx   = cnt + CNT_W'(1);
                if (dmem_ack) begin
                    load_buf_nx = MemRead_in ? load_data : 32'd0;
                    state_nx    = DONE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    load_buf_nx  = 32'd0;
                    timed_out_nx = 1'b1;
                    state_nx     = DONE;
                end
            end
            DONE: begin
                state_nx     = IDLE;
                mem_err      = timed_out;
                RegWrite_out = reg_ok & ~timed_out;
                MemRead_out  = ex_valid & MemRead_in & ~timed_out;
                Mem_out      = load_buf;
            end
            default: state_nx = IDLE;
        endcase
        if (rst) begin
            dmem_req     = 1'b0;
            dmem_we      = 1'b0;
            dmem_addr    = 32'd0;
            dmem_be      = 4'd0;
            dmem_wdata   = 32'd0;
            stall        = 1'b0;
            mem_err      = 1'b0;
            RegWrite_out = 1'b0;
            MemRead_out  = 1'b0;
            Mem_out      = 32'd0;
            ALU_out      = 32'd0;
            Rd_out       = 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            load_buf  <= 32'd0;
            timed_out <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            load_buf  <= load_buf_nx;
            timed_out <= timed_out_nx;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus randomized ops checked
// against a transaction-level model of alignment, latency and error rules.
module tb_mem_access_stage;

    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, MemRead_in, MemWrite_in, RegWrite_in, MemSigned_in;
    logic [1:0]  MemSize_in;
    logic [31:0] ALU_in, StoreData_in, dmem_rdata;
    logic [4:0]  Rd_in;
    logic        dmem_ack;
    logic        dmem_req, dmem_we, stall, mem_err, RegWrite_out, MemRead_out;
    logic [31:0] dmem_addr, dmem_wdata, Mem_out, ALU_out;
    logic [3:0]  dmem_be;
    logic [4:0]  Rd_out;

    int n_tests = 0;
    int n_fail  = 0;

    // Observations from the last run_op
    logic        o_req0, o_we, f_rw, f_mr, stable, bound_hit, post_req;
    logic [3:0]  o_be;
    logic [31:0] o_wdata, o_addr, f_mem, f_alu;
    int          stall_cnt, errs;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .MemRead_in(MemRead_in),
        .MemWrite_in(MemWrite_in), .RegWrite_in(RegWrite_in), .MemSize_in(MemSize_in),
        .MemSigned_in(MemSigned_in), .ALU_in(ALU_in), .StoreData_in(StoreData_in),
        .Rd_in(Rd_in), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .stall(stall), .mem_err(mem_err),
        .RegWrite_out(RegWrite_out), .MemRead_out(MemRead_out), .Mem_out(Mem_out),
        .ALU_out(ALU_out), .Rd_out(Rd_out)
    );

    // Reference rules, stated arithmetically
    function automatic logic model_bad(logic r, logic w, logic [1:0] sz, logic [31:0] a);
        return (r && w) || sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    endfunction

    function automatic logic [3:0] model_be(logic [1:0] sz, logic [31:0] a);
        int k = int'(a % 4);
        if (sz == 2'd0) return 4'(1 << k);
        if (sz == 2'd1) return (k >= 2) ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    function automatic logic [31:0] model_wdata(logic [1:0] sz, logic [31:0] d);
        if (sz == 2'd0) return (d % 256) * 32'h0101_0101;
        if (sz == 2'd1) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(logic [1:0] sz, logic sg, logic [31:0] a,
                                               logic [31:0] rdata);
        int width = (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : 32;
        logic [31:0] mask, v;
        if (width == 32) return rdata;
        mask = (32'd1 << width) - 32'd1;
        v = (rdata >> (8 * (a % 4))) & mask;
        if (sg && v >= (mask + 32'd1) / 2) v = v | ~mask;
        return v;
    endfunction

    task automatic idle_inputs();
        ex_valid = 0; MemRead_in = 0; MemWrite_in = 0; RegWrite_in = 0;
        MemSize_in = 0; MemSigned_in = 0; ALU_in = 0; StoreData_in = 0;
        Rd_in = 0; dmem_ack = 0; dmem_rdata = 0;
    endtask

    // Issue one instruction at posedge+1 and act as the memory; delay<0 means never ack
    task automatic run_op(input logic r, input logic w, input logic rw, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a, input logic [31:0] sd,
                          input logic [4:0] rd, input int delay, input logic [31:0] rdata);
        int  c = 0;
        logic done = 0;
        ex_valid = 1; MemRead_in = r; MemWrite_in = w; RegWrite_in = rw; MemSize_in = sz;
        MemSigned_in = sg; ALU_in = a; StoreData_in = sd; Rd_in = rd;
        dmem_ack = 0; dmem_rdata = rdata;
        stall_cnt = 0; errs = 0; stable = 1; bound_hit = 0;
        @(negedge clk);
        o_req0 = dmem_req; o_we = dmem_we; o_be = dmem_be; o_wdata = dmem_wdata; o_addr = dmem_addr;
        errs += int'(mem_err);
        if (stall) stall_cnt++;
        else begin done = 1; f_rw = RegWrite_out; f_mr = MemRead_out; f_mem = Mem_out; f_alu = ALU_out; end
        while (!done && c < 200) begin
            @(posedge clk); #1;
            c++;
            dmem_ack = (delay >= 0 && c == delay + 1);
            @(negedge clk);
            errs += int'(mem_err);
            if (stall && dmem_req && (dmem_be !== o_be || dmem_wdata !== o_wdata ||
                dmem_addr !== o_addr || dmem_we !== o_we)) stable = 0;
            if (stall) stall_cnt++;
            else begin done = 1; f_rw = RegWrite_out; f_mr = MemRead_out; f_mem = Mem_out; f_alu = ALU_out; end
        end
        if (!done) bound_hit = 1;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        errs += int'(mem_err);
        post_req = dmem_req;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1; ex_valid = 1; MemRead_in = 1; MemSize_in = 2; ALU_in = 32'h100;
        RegWrite_in = 1; Rd_in = 5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", dmem_req); end
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
        n_tests++; if (RegWrite_out !== 1'b0 || mem_err !== 1'b0 || MemRead_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctl got rw=%b err=%b mr=%b want 0", RegWrite_out, mem_err, MemRead_out); end
        n_tests++; if (ALU_out !== 32'd0 || Mem_out !== 32'd0 || Rd_out !== 5'd0) begin
            n_fail++; $display("FAIL reset_data got alu=%h mem=%h rd=%0d want 0", ALU_out, Mem_out, Rd_out); end
        @(posedge clk); #1;
        idle_inputs(); rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_alu_op();
        run_op(0, 0, 1, 2'd2, 0, 32'h1234, 32'h0, 5'd8, 0, 32'h0);
        n_tests++; if (o_req0 !== 1'b0 || stall_cnt != 0) begin
            n_fail++; $display("FAIL alu_bus got req=%b stall=%0d want 0/0", o_req0, stall_cnt); end
        n_tests++; if (f_rw !== 1'b1 || f_alu !== 32'h1234 || f_mem !== 32'd0) begin
            n_fail++; $display("FAIL alu_out got rw=%b alu=%h mem=%h want 1/1234/0", f_rw, f_alu, f_mem); end
    endtask

    task automatic test_load_byte();
        run_op(1, 0, 1, 2'd0, 1, 32'h103, 32'h0, 5'd4, 3, 32'h80FF_00AA);
        n_tests++; if (stall_cnt != 5 || bound_hit) begin
            n_fail++; $display("FAIL lb_stall got %0d want 5", stall_cnt); end
        n_tests++; if (f_mem !== 32'hFFFF_FF80 || f_rw !== 1'b1 || f_mr !== 1'b1) begin
            n_fail++; $display("FAIL lb_data got %h rw=%b mr=%b want ffffff80/1/1", f_mem, f_rw, f_mr); end
        n_tests++; if (o_addr !== 32'h100 || o_be !== 4'hF || o_we !== 1'b0) begin
            n_fail++; $display("FAIL lb_bus got addr=%h be=%b we=%b want 100/1111/0", o_addr, o_be, o_we); end
        run_op(1, 0, 1, 2'd0, 0, 32'h103, 32'h0, 5'd4, 3, 32'h80FF_00AA);
        n_tests++; if (f_mem !== 32'h0000_0080) begin
            n_fail++; $display("FAIL lbu_data got %h want 00000080", f_mem); end
    endtask

    task automatic test_store_half();
        run_op(0, 1, 0, 2'd1, 0, 32'h102, 32'h0000_BEEF, 5'd0, 1, 32'h0);
        n_tests++; if (o_be !== 4'b1100 || o_wdata !== 32'hBEEF_BEEF || o_we !== 1'b1 || o_req0 !== 1'b1) begin
            n_fail++; $display("FAIL sh_bus got be=%b wd=%h we=%b req=%b want 1100/beefbeef/1/1",
                               o_be, o_wdata, o_we, o_req0); end
        n_tests++; if (f_rw !== 1'b0 || stall_cnt != 3 || !stable) begin
            n_fail++; $display("FAIL sh_done got rw=%b stall=%0d stable=%b want 0/3/1", f_rw, stall_cnt, stable); end
    endtask

    task automatic test_bad_access();
        run_op(1, 0, 1, 2'd2, 0, 32'h102, 32'h0, 5'd7, 0, 32'h0);
        n_tests++; if (o_req0 !== 1'b0 || stall_cnt != 0 || errs != 1 || f_rw !== 1'b0) begin
            n_fail++; $display("FAIL lw_misalign got req=%b stall=%0d errs=%0d rw=%b want 0/0/1/0",
                               o_req0, stall_cnt, errs, f_rw); end
        run_op(1, 0, 1, 2'd3, 0, 32'h100, 32'h0, 5'd7, 0, 32'h0);
        n_tests++; if (o_req0 !== 1'b0 || errs != 1 || f_mr !== 1'b0) begin
            n_fail++; $display("FAIL illegal_size got req=%b errs=%0d mr=%b want 0/1/0", o_req0, errs, f_mr); end
    endtask

    task automatic test_timeout();
        run_op(1, 0, 1, 2'd2, 0, 32'h200, 32'h0, 5'd9, -1, 32'h0);
        n_tests++; if (stall_cnt != TIMEOUT + 1 || bound_hit || post_req !== 1'b0) begin
            n_fail++; $display("FAIL timeout_len got stall=%0d req_after=%b want %0d/0", stall_cnt, post_req, TIMEOUT + 1); end
        n_tests++; if (errs != 1 || f_rw !== 1'b0 || f_mem !== 32'd0) begin
            n_fail++; $display("FAIL timeout_err got errs=%0d rw=%b mem=%h want 1/0/0", errs, f_rw, f_mem); end
        dmem_ack = 1; dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_tests++; if (dmem_req !== 1'b0 || stall !== 1'b0 || mem_err !== 1'b0) begin
            n_fail++; $display("FAIL stray_ack got req=%b stall=%b err=%b want 0", dmem_req, stall, mem_err); end
        @(posedge clk); #1;
        dmem_ack = 0;
        @(negedge clk);
        n_tests++; if (stall !== 1'b0 || Mem_out !== 32'd0 || mem_err !== 1'b0) begin
            n_fail++; $display("FAIL stray_after got stall=%b mem=%h err=%b want 0", stall, Mem_out, mem_err); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_in_wait();
        int bad_ev = 0;
        ex_valid = 1; MemRead_in = 1; RegWrite_in = 1; MemSize_in = 2; ALU_in = 32'h300; Rd_in = 6;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0; idle_inputs();
        @(negedge clk);
        n_tests++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin
            n_fail++; $display("FAIL rst_wait got req=%b stall=%b want 0/0", dmem_req, stall); end
        repeat (3) begin
            if (mem_err !== 1'b0 || RegWrite_out !== 1'b0 || dmem_req !== 1'b0) bad_ev++;
            @(negedge clk);
        end
        n_tests++; if (bad_ev != 0) begin
            n_fail++; $display("FAIL rst_wait_quiet got %0d stray events want 0", bad_ev); end
        @(posedge clk); #1;
        run_op(1, 0, 1, 2'd2, 0, 32'h40, 32'h0, 5'd0, 0, 32'h1111_2222);
        n_tests++; if (f_rw !== 1'b0 || f_mr !== 1'b1 || stall_cnt != 2 || f_mem !== 32'h1111_2222) begin
            n_fail++; $display("FAIL lw_r0 got rw=%b mr=%b stall=%0d mem=%h want 0/1/2/11112222",
                               f_rw, f_mr, stall_cnt, f_mem); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            int          kind  = int'($urandom_range(0, 9));
            logic        r     = (kind < 4) || kind == 9;
            logic        w     = (kind >= 4 && kind < 7) || kind == 9;
            logic [1:0]  sz    = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            logic        sg    = 1'($urandom);
            logic        rw    = 1'($urandom);
            logic [4:0]  rd    = 5'($urandom);
            logic [31:0] a     = $urandom;
            logic [31:0] sd    = $urandom;
            logic [31:0] rdata = $urandom;
            int          delay = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
            logic        mop, bd, to, exp_rw, exp_mr;
            int          exp_stall, exp_err;
            if ($urandom_range(0, 1) == 1 && sz == 2'd2) a = a & 32'hFFFF_FFFC;
            if ($urandom_range(0, 1) == 1 && sz == 2'd1) a = a & 32'hFFFF_FFFE;
            run_op(r, w, rw, sz, sg, a, sd, rd, delay, rdata);
            mop = r || w;
            bd  = mop && model_bad(r, w, sz, a);
            to  = mop && !bd && delay < 0;
            exp_stall = (!mop || bd) ? 0 : (to ? TIMEOUT + 1 : delay + 2);
            exp_err   = (bd || to) ? 1 : 0;
            exp_rw    = rw && rd != 0 && !w && !bd && !to;
            exp_mr    = r && !bd && !to;
            n_tests++; if (stall_cnt != exp_stall || errs != exp_err || o_req0 !== (mop && !bd)) begin
                n_fail++; $display("FAIL rnd%0d_flow got stall=%0d err=%0d req=%b want %0d/%0d/%b",
                                   i, stall_cnt, errs, o_req0, exp_stall, exp_err, mop && !bd); end
            n_tests++; if (f_rw !== exp_rw || f_mr !== exp_mr || f_alu !== a || !stable) begin
                n_fail++; $display("FAIL rnd%0d_ctl got rw=%b mr=%b alu=%h stable=%b want %b/%b/%h/1",
                                   i, f_rw, f_mr, f_alu, stable, exp_rw, exp_mr, a); end
            if (w && !bd) begin
                n_tests++; if (o_be !== model_be(sz, a) || o_wdata !== model_wdata(sz, sd) || o_we !== 1'b1 ||
                               o_addr !== (a & 32'hFFFF_FFFC)) begin
                    n_fail++; $display("FAIL rnd%0d_store got be=%b wd=%h we=%b addr=%h want %b/%h/1/%h", i,
                                       o_be, o_wdata, o_we, o_addr, model_be(sz, a), model_wdata(sz, sd),
                                       a & 32'hFFFF_FFFC); end
            end
            if (r && !w) begin
                logic [31:0] exp_mem = exp_mr ? model_load(sz, sg, a, rdata) : 32'd0;
                n_tests++; if (f_mem !== exp_mem) begin
                    n_fail++; $display("FAIL rnd%0d_load got %h want %h", i, f_mem, exp_mem); end
            end
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        #1;
        test_reset();
        test_alu_op();
        test_load_byte();
        test_store_half();
        test_bad_access();
        test_timeout();
        test_reset_in_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
